// File: rtl/dts_result_drain_pkg.sv
// Shared definitions for the DTS result drain: FSM state encoding,
// default guard lengths and the row-index width helper.
package dts_result_drain_pkg;

  typedef enum logic [3:0] {
    IDLE,
    POLL,
    GUARD,
    WAIT_READY,
    HEADER,
    READ,
    CAPTURE,
    PRESENT,
    RESUME
  } drain_state_t;

  localparam int DEF_POLL_GUARD   = 3;
  localparam int DEF_RESUME_GUARD = 2;
  localparam int DEF_ROWS         = 3;

  // Width needed to index v items, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int DEF_ROW_IDX_W = clog2_min1(DEF_ROWS);

endpackage

// File: rtl/dts_guard_timer.sv
// Loadable down-counter with a zero flag. Used to blank an input for a
// fixed number of cycles after an event; it parks at zero once expired.
module dts_guard_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down until zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dts_result_drain.sv
// Drains one solution at a time from the DTS worker array: poll, wait for
// the result RAM, stream its rows out, then broadcast resume.
// Optional build macro DTS_DRAIN_HEADER_EN prefixes each solution with a
// header word carrying the number of solutions drained so far.
module dts_result_drain
  import dts_result_drain_pkg::*;
#(
  parameter int n            = 3,
  parameter int M            = 19,
  parameter int POLL_GUARD   = DEF_POLL_GUARD,
  parameter int RESUME_GUARD = DEF_RESUME_GUARD,
  parameter int CNT_W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        doneAggregate,
  input  logic                        ready,
  output logic                        poll,
  output logic [clog2_min1(n)-1:0]    rowAddr,
  input  logic [M:0]                  row,
  output logic                        anotherOneBroadcast,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [M:0]                  out_data,
  output logic                        out_last,
  output logic [CNT_W-1:0]            sol_count,
  output logic                        busy
);

  localparam int AW   = clog2_min1(n);
  localparam int MAXG = (POLL_GUARD > RESUME_GUARD) ? POLL_GUARD : RESUME_GUARD;
  localparam int GW   = clog2_min1(MAXG + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(n - 1);

  drain_state_t  state;
  logic [AW-1:0] r_idx;
  logic          poll_zero;
  logic          resume_zero;

  // Poll guard: loaded while poll is high, blanks ready until expiry.
  dts_guard_timer #(.W(GW)) u_poll_guard (
    .clk   (clk),
    .reset (reset),
    .load  (state == POLL),
    .value (GW'(POLL_GUARD)),
    .zero  (poll_zero)
  );

  // Resume guard: loaded during the resume pulse, blanks doneAggregate in IDLE.
  dts_guard_timer #(.W(GW)) u_resume_guard (
    .clk   (clk),
    .reset (reset),
    .load  (state == RESUME),
    .value (GW'(RESUME_GUARD)),
    .zero  (resume_zero)
  );

`ifdef DTS_DRAIN_HEADER_EN
  // Header word: solution count zero-extended or truncated to row width.
  logic [M:0] hdr_word;
  for (genvar gi = 0; gi < M + 1; gi++) begin : g_hdr
    if (gi < CNT_W) begin : g_cnt
      assign hdr_word[gi] = sol_count[gi];
    end else begin : g_zero
      assign hdr_word[gi] = 1'b0;
    end
  end
`endif

  // Drain sequencer with registered pulse, address and stream outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      poll                <= 1'b0;
      anotherOneBroadcast <= 1'b0;
      rowAddr             <= '0;
      r_idx               <= '0;
      out_valid           <= 1'b0;
      out_data            <= '0;
      out_last            <= 1'b0;
      sol_count           <= '0;
    end else begin
      poll                <= 1'b0;
      anotherOneBroadcast <= 1'b0;
      case (state)
        IDLE: begin
          if (run && doneAggregate && resume_zero) begin
            poll  <= 1'b1;
            state <= POLL;
          end
        end
        POLL: state <= GUARD;
        GUARD: begin
          if (poll_zero) state <= WAIT_READY;
        end
        WAIT_READY: begin
          if (ready) begin
            r_idx   <= '0;
            rowAddr <= '0;
`ifdef DTS_DRAIN_HEADER_EN
            out_data  <= hdr_word;
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            state     <= HEADER;
`else
            state     <= READ;
`endif
          end
        end
        HEADER: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= READ;
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          // RAM output now reflects rowAddr presented during READ.
          out_data  <= row;
          out_last  <= (r_idx == LAST_IDX);
          out_valid <= 1'b1;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              sol_count           <= sol_count + 1'b1;
              anotherOneBroadcast <= 1'b1;
              state               <= RESUME;
            end else begin
              r_idx   <= r_idx + 1'b1;
              rowAddr <= r_idx + 1'b1;
              state   <= READ;
            end
          end
        end
        RESUME: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_dts_result_drain.sv
// Scoreboard bench for dts_result_drain: expected stream words are queued
// as each solution is staged; a monitor pops and compares on handshakes.
module tb_dts_result_drain;

  localparam int N  = 3;
  localparam int M  = 19;
  localparam int CW = 16;
`ifdef DTS_DRAIN_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          doneAggregate = 1'b0;
  logic          ready = 1'b0;
  logic          out_ready = 1'b1;
  logic          poll;
  logic [1:0]    rowAddr;
  logic [M:0]    row = '0;
  logic          anotherOneBroadcast;
  logic          out_valid;
  logic [M:0]    out_data;
  logic          out_last;
  logic [CW-1:0] sol_count;
  logic          busy;

  dts_result_drain #(
    .n(N), .M(M), .POLL_GUARD(3), .RESUME_GUARD(2), .CNT_W(CW)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .run                 (run),
    .doneAggregate       (doneAggregate),
    .ready               (ready),
    .poll                (poll),
    .rowAddr             (rowAddr),
    .row                 (row),
    .anotherOneBroadcast (anotherOneBroadcast),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_data            (out_data),
    .out_last            (out_last),
    .sol_count           (sol_count),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result RAM model with registered read.
  logic [M:0] ram [N];
  always @(posedge clk) row <= ram[rowAddr];

  logic [M+1:0] exp_q[$];
  logic [M+1:0] mon_e;
  int tests = 0, fails = 0;
  int poll_cnt = 0, aob_cnt = 0, hs_cnt = 0;
  int exp_sol = 0, exp_poll = 0, exp_aob = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse counters.
  always @(negedge clk) begin
    if (poll) poll_cnt++;
    if (anotherOneBroadcast) aob_cnt++;
  end

  // Stream monitor: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      hs_cnt++;
      tests++;
      $display("[TB] word data=0x%05h last=%0b sol_count=%0d", out_data, out_last, sol_count);
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream_word: got data=0x%05h last=%0b, expected no word", out_data, out_last);
      end else begin
        mon_e = exp_q.pop_front();
        if ({out_last, out_data} !== mon_e) begin
          fails++;
          $display("FAIL stream_word: got data=0x%05h last=%0b, expected data=0x%05h last=%0b",
                   out_data, out_last, mon_e[M:0], mon_e[M+1]);
        end
      end
    end
  end

  task automatic wait_sig(input string name, input int sel);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if ((sel == 0 && poll) || (sel == 1 && anotherOneBroadcast) || (sel == 2 && out_valid))
        return;
    end
    tests++;
    fails++;
    $display("FAIL timeout_%s: event absent after 300 cycles, expected it", name);
  endtask

  task automatic wait_hs(input int target);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (hs_cnt >= target) return;
    end
    tests++;
    fails++;
    $display("FAIL timeout_handshake: count %0d, expected %0d", hs_cnt, target);
  endtask

  task automatic push_sol(input logic [M:0] r0, input logic [M:0] r1, input logic [M:0] r2);
`ifdef DTS_DRAIN_HEADER_EN
    logic [31:0] s;
    s = exp_sol;
    exp_q.push_back({1'b0, s[M:0]});
`endif
    exp_q.push_back({1'b0, r0});
    exp_q.push_back({1'b0, r1});
    exp_q.push_back({1'b1, r2});
  endtask

  task automatic run_solution(input logic [M:0] r0, input logic [M:0] r1, input logic [M:0] r2,
                              input bit hold_ready, input bit check_lat,
                              input int stall, input bit keep_done);
    int c0, p0, hs0;
    ram[0] = r0; ram[1] = r1; ram[2] = r2;
    push_sol(r0, r1, r2);
    hs0 = hs_cnt;
    ready = hold_ready;
    doneAggregate = 1'b1;
    wait_sig("poll", 0);
    c0 = cyc;
    if (!keep_done) doneAggregate = 1'b0;
    if (!hold_ready) begin
      repeat (4) @(posedge clk);
      #1 ready = 1'b1;
    end
    if (check_lat) begin
      wait_sig("first_valid", 2);
      check("guard_latency", cyc - c0, (HDR != 0) ? 6 : 8);
    end
    if (stall > 0) begin
      wait_hs(hs0 + HDR + 1);
      @(posedge clk);
      #1 out_ready = 1'b0;
      wait_sig("word1_valid", 2);
      for (int i = 0; i < stall; i++) begin
        check("stall_data", out_data, r1);
        check("stall_rowaddr", rowAddr, 1);
        check("stall_valid", out_valid, 1);
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
    end
    wait_sig("resume", 1);
    ready = 1'b0;
    exp_sol++;
    exp_poll++;
    exp_aob++;
    check("sol_count", sol_count, exp_sol % 65536);
    p0 = poll_cnt;
    @(posedge clk);
    if (keep_done) @(posedge clk);
    #1;
    doneAggregate = 1'b0;
    check("resume_single_cycle", anotherOneBroadcast, 0);
    check("resume_pulses", aob_cnt, exp_aob);
    if (keep_done) begin
      repeat (10) @(negedge clk);
      check("no_repoll_in_guard", poll_cnt, p0);
      @(posedge clk);
      #1;
    end
    check("poll_pulses", poll_cnt, exp_poll);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int a0, p0, hs0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_poll", poll, 0);
    check("reset_resume", anotherOneBroadcast, 0);
    check("reset_rowaddr", rowAddr, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_last", out_last, 0);
    check("reset_sol_count", sol_count, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    run = 1'b1;
    while (cyc < 10) @(posedge clk);
    #1;

    // Basic drain, ready four cycles after poll.
    run_solution(20'h00013, 20'h00A05, 20'h40001, 1'b0, 1'b0, 0, 1'b0);
    // Ready held high through the poll: words wait out the guard.
    run_solution(20'hFFFFF, 20'h00000, 20'h12345, 1'b1, 1'b1, 0, 1'b0);
    // Backpressure on word 1 for five cycles.
    run_solution(20'h00013, 20'h00A05, 20'h40001, 1'b1, 1'b0, 5, 1'b0);
    // doneAggregate lingers after resume.
    run_solution(20'h0ABCD, 20'h80000, 20'h00001, 1'b1, 1'b0, 0, 1'b1);
    // A later genuine solution.
    run_solution(20'h11111, 20'h22222, 20'h33333, 1'b0, 1'b0, 0, 1'b0);

    // Reset while word 1 is presented.
    ram[0] = 20'h00013; ram[1] = 20'h00A05; ram[2] = 20'h40001;
    push_sol(20'h00013, 20'h00A05, 20'h40001);
    hs0 = hs_cnt;
    ready = 1'b1;
    doneAggregate = 1'b1;
    wait_sig("abort_poll", 0);
    doneAggregate = 1'b0;
    exp_poll++;
    wait_hs(hs0 + HDR + 1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    wait_sig("abort_valid", 2);
    a0 = aob_cnt;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_sol_count", sol_count, 0);
    check("abort_busy", busy, 0);
    check("abort_rowaddr", rowAddr, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run = 1'b0;
    out_ready = 1'b1;
    ready = 1'b0;
    exp_q.delete();
    exp_sol = 0;
    doneAggregate = 1'b1;
    p0 = poll_cnt;
    repeat (20) @(negedge clk);
    check("run_low_no_poll", poll_cnt, p0);
    check("abort_no_resume", aob_cnt, a0);
    check("run_low_idle", busy, 0);
    doneAggregate = 1'b0;
    run = 1'b1;
    @(posedge clk);
    #1;

    // Two fresh solutions after reset (headers 0 and 1 when enabled).
    run_solution(20'h00001, 20'h00002, 20'h00003, 1'b0, 1'b0, 0, 1'b0);
    run_solution(20'hC0FFE, 20'h0BEEF, 20'h7FFFF, 1'b1, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dts_result_drain.md
Name: dts_result_drain

Overview:
- Downstream consumer of the multi-worker DTS search array.
- Watches the aggregated done flag and pulses poll to latch the result RAM. Waits for ready, then reads the n result rows through the row-address port.
- Emits the rows on a valid/ready stream toward the host link. Then pulses anotherOneBroadcast so the workers resume the search.
- Counts solutions drained.

Parameters:
- n, 3, rows per solution (num blocks); rowAddr width is $clog2(n).
- M, 19, max mark; row width is M+1.
- POLL_GUARD, 3, cycles after a poll pulse during which ready is ignored; covers the worker's registered poll plus its registered ready.
- RESUME_GUARD, 2, cycles after anotherOneBroadcast during which doneAggregate is ignored.
- CNT_W, 16, solution counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- run  in  1  level; when low, no new drain starts (a drain in progress completes)
- doneAggregate  in  1  any worker holds a solution
- ready  in  1  result RAM filled and held
- poll  out  1  one-cycle pulse requesting selection/fill
- rowAddr  out  $clog2(n)  result RAM read address
- row  in  M+1  result RAM data; registered read, valid one cycle after rowAddr
- anotherOneBroadcast  out  1  one-cycle pulse: resume all workers
- out_valid  out  1  stream word valid
- out_ready  in  1  stream sink accepts
- out_data  out  M+1  stream word
- out_last  out  1  marks last word of a solution
- sol_count  out  CNT_W  solutions fully drained; wraps modulo 2^CNT_W
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: poll=0, anotherOneBroadcast=0, rowAddr=0, out_valid=0, out_data=0, out_last=0, sol_count=0, busy=0. The FSM goes to IDLE and all counters clear.
- Reset mid-operation aborts immediately; no further poll or anotherOne pulse is issued.
- IDLE -> POLL when run && doneAggregate, and the resume guard counter is 0.
- POLL: poll=1 for exactly one cycle; load the guard counter with POLL_GUARD; go to GUARD.
- GUARD: decrement the counter; ready is ignored. At 0, go to WAIT_READY.
- WAIT_READY: wait indefinitely for ready=1. Set word index r=0 and rowAddr=0, then go to READ.
- READ: rowAddr=r held for one cycle; go to CAPTURE.
- CAPTURE: out_data<=row, out_valid<=1, out_last<=(r==n-1); go to PRESENT.
- PRESENT: out_data and out_last stay stable while out_valid && !out_ready.
- On handshake (out_valid && out_ready):
  - if r==n-1: out_valid<=0; sol_count+1; go to RESUME.
  - else: r+1; rowAddr<=r+1; go to READ.
- Throughput: one word per 3 cycles. rowAddr is held constant through PRESENT, so the RAM output stays stable under backpressure.
- RESUME: anotherOneBroadcast=1 for exactly one cycle; load the resume guard with RESUME_GUARD; go to IDLE. The guard counts down in IDLE.
- If ready drops while in READ/CAPTURE/PRESENT (protocol violation), the drain still completes from the RAM. Data is undefined; no special handling.
- run deasserted mid-drain: no effect until IDLE.
- doneAggregate high again immediately after resume is honoured only after the guard expires.
- rowAddr outside READ/PRESENT holds its last value.

Optional Feature:
- Macro DTS_DRAIN_HEADER_EN.
- Defined:
  - Each solution is preceded by one header word out_data = sol_count (value before increment), zero-extended or truncated to M+1 bits; out_last=0.
  - Header state HEADER is inserted between WAIT_READY and READ, with the same valid/ready rules.
  - Each solution is n+1 words.
- Undefined: exactly n words per solution, no header logic.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, POLL, GUARD, WAIT_READY, HEADER, READ, CAPTURE, PRESENT, RESUME
  - a clog2-based width constant for the row index
  - default POLL_GUARD and RESUME_GUARD constants
- One natural sub-module: dts_guard_timer, a loadable down-counter with a zero flag, instantiated twice (poll guard and resume guard).

Test Plan:
- n=3, M=19. doneAggregate=1 at cycle 10, ready rises 4 cycles after poll, RAM rows {0x00013, 0x00A05, 0x40001}, out_ready=1 -> exactly one poll pulse. Words 0x00013, 0x00A05, 0x40001 appear in order, with out_last only on the third word. anotherOne pulses once; sol_count=1.
- Hold ready=1 continuously before and through the poll pulse -> no word emitted until POLL_GUARD cycles elapse, then a normal drain.
- out_ready low for 5 cycles on word 1 -> out_data=0x00A05 stable for all 5 cycles, rowAddr=1 held, no duplicate or lost word.
- doneAggregate stays 1 for one cycle after anotherOne -> no second poll within RESUME_GUARD cycles. A real second solution later increments sol_count to 2.
- Assert reset during PRESENT of word 1 -> next cycle out_valid=0 and sol_count=0, no anotherOne pulse. Then run=0 keeps the block idle despite doneAggregate=1.
- With DTS_DRAIN_HEADER_EN defined, two solutions -> header words 0 then 1, each followed by 3 rows.
